compare_arbiter: RTL and testbench
==================================

Name: compare_arbiter

Overview:
- Shares one registered magnitude comparator among NUM_REQ requesters.
- Each requester presents an operand pair with valid/ready.
- A round-robin arbiter grants one requester at a time, latches its operands and runs the compare.
- Returns gt/eq/lt tagged with the requester id over a valid/ready response port.
- Sits between multiple datapath clients and the single compare resource.

Parameters:
- DATA_WIDTH, 4: operand width in bits.
- NUM_REQ, 4: number of requesters, 2..16.
- ID_W, $clog2(NUM_REQ): width of the requester id (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand pair valid.
- req_a  input  NUM_REQ*DATA_WIDTH  packed operand A; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  input  NUM_REQ*DATA_WIDTH  packed operand B, same packing as req_a.
- req_ready  output  NUM_REQ  one-hot accept strobe.
- rsp_valid  output  1  result valid.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_gt  output  1  A > B.
- rsp_eq  output  1  A == B.
- rsp_lt  output  1  A < B.
- rsp_ready  input  1  consumer accepts the result.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_gt/eq/lt=0, busy=0.
  - Operand registers cleared.
- State IDLE:
  - If any req_valid is high, select the winner: the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[winner] is driven combinationally high in the same cycle; the handshake completes that cycle.
  - Operands and winner id are latched; next state is CMP.
  - req_ready is all-zero in every state other than IDLE.
- State CMP (1 cycle):
  - The comparator evaluates the latched operands; gt/eq/lt are registered into the rsp_* outputs and rsp_id=winner.
  - rsp_valid is set; next state is RESP.
- State RESP:
  - rsp_valid and all rsp_* outputs are held stable until rsp_ready=1.
  - On that cycle: rsp_valid goes low next cycle, rr_ptr = (winner+1) mod NUM_REQ, next state is IDLE.
- Latency: acceptance at cycle T puts rsp_valid high at T+2. Minimum issue interval is 3 cycles with rsp_ready tied high.
- Exactly one of rsp_gt/eq/lt is high while rsp_valid=1.
- Comparison is unsigned by default.
- Boundary conditions:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - A requester that drops req_valid before being granted is simply skipped; no state is retained for it.
  - Back-to-back requests from the same requester only win again after every other pending requester has been served (fairness).
  - rsp_ready high in a cycle where rsp_valid is low has no effect.
  - rst asserted mid-transaction aborts it: the pending result is discarded and no response is issued.
  - When NUM_REQ is not a power of two, the pointer still wraps at NUM_REQ, not 2^ID_W.

Optional Feature:
- Macro: COMPARE_ARBITER_SIGNED_EN.
- Defined: operands are compared as two's-complement signed values, e.g. A=4'b1000 (-8) vs B=4'b0001 gives rsp_lt=1.
- Undefined: unsigned compare; the same operands give rsp_gt=1.
- Handshake, latency and arbitration are identical in both builds.

Decomposition:
- Package compare_arbiter_pkg:
  - state enum {IDLE, CMP, RESP} in 2 bits.
  - Function next_rr(ptr, NUM_REQ) for the wrap computation.
  - Localparam helper for ID_W.
- One sub-module, mag_compare_core:
  - Parameterised DATA_WIDTH, combinational, produces gt/eq/lt.
  - Signedness is selected by the same macro.
  - The arbiter registers its outputs.

Test Plan:
- Single request: req_valid=4'b0010, a1=9, b1=3, rsp_ready=1 -> req_ready=4'b0010 at T, rsp_valid at T+2 with rsp_id=1, gt=1, eq=0, lt=0.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches its grant.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready=0 throughout; rsp_ready=1 then returns to IDLE next cycle.
- Equal/less: a=b=4'hA -> eq=1 only; a=2, b=7 -> lt=1 only; a=4'hF, b=0 unsigned -> gt=1 (signed build: lt=1).
- Reset mid-op: assert rst during RESP -> rsp_valid, busy and req_ready are 0 immediately, rr_ptr=0, and the next grant goes to the lowest active requester.
- Wrap with NUM_REQ=3: requests on 2 then 0 -> rr_ptr goes 0→... after serving 2 wraps to 0; requester 0 is granted next.

Source files
------------

// File: rtl/compare_arbiter_pkg.sv
// Shared types and helpers for compare_arbiter.
//   state_e  : arbiter FSM state (idle, compare, response hold)
//   id_width : requester-id width derived from the requester count (min 1)
//   next_rr  : round-robin pointer advance, wrapping at num_req (not a power of two)
// Build option: define COMPARE_ARBITER_SIGNED_EN for two's-complement compares.
package compare_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StResp = 2'd2
    } state_e;

    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned num_req);
        return (ptr + 1 >= num_req) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/compare_arbiter_if.sv
// Request/response bundle between datapath clients and compare_arbiter.
//   req_valid/req_ready : per-requester handshake (req_ready is one-hot)
//   req_a/req_b         : packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_*               : tagged result with valid/ready handshake
//   busy                : arbiter is not idle
// modport slave is the arbiter side, master the client/consumer side.
interface compare_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 4
);
    import compare_arbiter_pkg::*;

    localparam int unsigned ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rsp_valid;
    logic [ID_W-1:0]               rsp_id;
    logic                          rsp_gt;
    logic                          rsp_eq;
    logic                          rsp_lt;
    logic                          rsp_ready;
    logic                          busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy
    );

endinterface

// File: rtl/mag_compare_core.sv
// Combinational magnitude comparator; exactly one of gt/eq/lt is high.
//   a, b       : operands (DATA_WIDTH bits)
//   gt, eq, lt : a > b, a == b, a < b
// Build option: COMPARE_ARBITER_SIGNED_EN selects a two's-complement compare,
// otherwise operands are unsigned.
module mag_compare_core #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  gt,
    output logic                  eq,
    output logic                  lt
);

`ifdef COMPARE_ARBITER_SIGNED_EN
    assign gt = $signed(a) > $signed(b);
    assign lt = $signed(a) < $signed(b);
`else
    assign gt = a > b;
    assign lt = a < b;
`endif
    assign eq = (a == b);

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one registered magnitude comparator among
// NUM_REQ requesters.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : compare_arbiter_if.slave (requests in, tagged gt/eq/lt result out, busy)
// Flow: IDLE grants one requester and latches its operands, CMP registers the
// compare result, RESP holds it until rsp_ready. Accept at T gives rsp_valid at T+2.
// Build option: COMPARE_ARBITER_SIGNED_EN (signed compare, see mag_compare_core).
module compare_arbiter
    import compare_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 4
) (
    input logic          clk,
    input logic          rst,
    compare_arbiter_if.slave bus
);

    localparam int unsigned ID_W = id_width(NUM_REQ);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       win_q, win_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic                  gt_q, gt_d;
    logic                  eq_q, eq_d;
    logic                  lt_q, lt_d;

    logic                  found;
    logic [ID_W-1:0]       winner;
    logic [ID_W-1:0]       scan_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  cmp_gt, cmp_eq, cmp_lt;

    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g] = bus.req_b[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            scan_idx = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Grant is combinational so the handshake completes in the selecting cycle;
    // masked during reset so nothing is accepted while the FSM is held.
    always_comb begin
        grant = '0;
        if (state_q == StIdle && found && !rst) begin
            grant[winner] = 1'b1;
        end
    end

    mag_compare_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .a  (a_q),
        .b  (b_q),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        gt_d        = gt_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d   = winner;
                    a_d     = a_arr[winner];
                    b_d     = b_arr[winner];
                    state_d = StCmp;
                end
            end
            StCmp: begin
                rsp_id_d    = win_q;
                gt_d        = cmp_gt;
                eq_d        = cmp_eq;
                lt_d        = cmp_lt;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = ID_W'(next_rr(32'(win_q), NUM_REQ));
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_gt    = gt_q;
    assign bus.rsp_eq    = eq_q;
    assign bus.rsp_lt    = lt_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_compare_arbiter.sv
// Scoreboard bench for compare_arbiter: a 4-requester instance and a 3-requester
// instance (non-power-of-two wrap). Expected results are pushed when a grant is
// seen; monitors pop and compare on each accepted response.
module tb_compare_arbiter;

    localparam int LT = 0;
    localparam int EQ = 1;
    localparam int GT = 2;
`ifdef COMPARE_ARBITER_SIGNED_EN
    localparam int NEG_VS_POS = LT;  // 4'hF/4'h8 are negative in the signed build
`else
    localparam int NEG_VS_POS = GT;
`endif

    typedef struct {
        int   id;
        logic gt;
        logic eq;
        logic lt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    compare_arbiter_if #(.DATA_WIDTH(4), .NUM_REQ(4)) bus ();
    compare_arbiter_if #(.DATA_WIDTH(4), .NUM_REQ(3)) bus3 ();

    compare_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    compare_arbiter #(.DATA_WIDTH(4), .NUM_REQ(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic [3:0] a4 [4];
    logic [3:0] b4 [4];
    logic [3:0] a3 [3];
    logic [3:0] b3 [3];
    assign bus.req_a  = {a4[3], a4[2], a4[1], a4[0]};
    assign bus.req_b  = {b4[3], b4[2], b4[1], b4[0]};
    assign bus3.req_a = {a3[2], a3[1], a3[0]};
    assign bus3.req_b = {b3[2], b3[1], b3[0]};

    exp_t q4[$];
    exp_t q3[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int id, input int code);
        exp_t e;
        e.id = id;
        e.gt = (code == GT);
        e.eq = (code == EQ);
        e.lt = (code == LT);
        return e;
    endfunction

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && bus.rsp_valid) begin
            check("rsp_onehot", $countones({bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}), 1);
            if (bus.rsp_ready) begin
                if (q4.size() == 0) begin
                    check("rsp_unexpected_id", 32'(bus.rsp_id), -1);
                end else begin
                    e = q4.pop_front();
                    check("rsp_id", 32'(bus.rsp_id), e.id);
                    check("rsp_gt", bus.rsp_gt, e.gt);
                    check("rsp_eq", bus.rsp_eq, e.eq);
                    check("rsp_lt", bus.rsp_lt, e.lt);
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (!rst && bus3.rsp_valid) begin
            check("rsp3_onehot", $countones({bus3.rsp_gt, bus3.rsp_eq, bus3.rsp_lt}), 1);
            if (bus3.rsp_ready) begin
                if (q3.size() == 0) begin
                    check("rsp3_unexpected_id", 32'(bus3.rsp_id), -1);
                end else begin
                    e = q3.pop_front();
                    check("rsp3_id", 32'(bus3.rsp_id), e.id);
                    check("rsp3_gt", bus3.rsp_gt, e.gt);
                    check("rsp3_eq", bus3.rsp_eq, e.eq);
                    check("rsp3_lt", bus3.rsp_lt, e.lt);
                end
            end
        end
    end

    // Waits (bounded) for any grant on the selected instance and checks it.
    task automatic wait_grant(input int which, input logic [3:0] exp, input string name);
        logic [3:0] seen;
        bit got;
        seen = '0;
        got  = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            seen = (which == 3) ? {1'b0, bus3.req_ready} : bus.req_ready;
            if (seen != 4'b0) got = 1'b1;
        end
        check(name, int'(seen), int'(exp));
    endtask

    task automatic wait_rsp(input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
        end
        check(name, bus.rsp_valid, 1);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (q4.size() == 0 && q3.size() == 0 && !bus.busy && !bus3.busy) done = 1'b1;
        end
        check(name, q4.size() + q3.size(), 0);
    endtask

    initial begin
        int rr_code [4];
        rr_code = '{EQ, LT, NEG_VS_POS, EQ};
        for (int i = 0; i < 4; i++) begin
            a4[i] = '0;
            b4[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            a3[i] = '0;
            b3[i] = '0;
        end
        bus.req_valid  = 4'b0101;  // pending during reset: must not be granted
        bus.rsp_ready  = 1'b0;
        bus3.req_valid = '0;
        bus3.rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        check("rst_rsp_flags", int'({bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}), 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;

        // Single request with latency check
        @(posedge clk); #1;
        a4[1] = 4'd9;
        b4[1] = 4'd3;
        bus.req_valid = 4'b0010;
        wait_grant(4, 4'b0010, "grant_single");
        q4.push_back(mk(1, GT));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("lat_t1_rsp_valid", bus.rsp_valid, 0);
        check("lat_t1_busy", bus.busy, 1);
        @(negedge clk);
        check("lat_t2_rsp_valid", bus.rsp_valid, 1);
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_rsp_valid", bus.rsp_valid, 0);

        // Round robin from a fresh pointer, all requesters held
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a4[0] = 4'd5; b4[0] = 4'd5;
        a4[1] = 4'd2; b4[1] = 4'd7;
        a4[2] = 4'hF; b4[2] = 4'h0;
        a4[3] = 4'hA; b4[3] = 4'hA;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(4, 4'b0001 << (k % 4), "grant_rr");
            q4.push_back(mk(k % 4, rr_code[k % 4]));
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain("drain_rr");

        // Backpressure: result held, no grants while stalled
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        a4[3] = 4'h8; b4[3] = 4'h1;
        bus.req_valid = 4'b1000;
        wait_grant(4, 4'b1000, "grant_bp");
        q4.push_back(mk(3, NEG_VS_POS));
        @(posedge clk); #1;
        a4[0] = 4'd2; b4[0] = 4'd7;
        bus.req_valid = 4'b0001;
        wait_rsp("rsp_bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_req_ready", int'(bus.req_ready), 0);
            check("bp_rsp_id", 32'(bus.rsp_id), 3);
            check("bp_rsp_gt", bus.rsp_gt, NEG_VS_POS == GT);
            check("bp_rsp_lt", bus.rsp_lt, NEG_VS_POS == LT);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_grant(4, 4'b0001, "grant_after_bp");
        check("busy_after_bp", bus.busy, 0);
        q4.push_back(mk(0, LT));
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain("drain_bp");

        // Reset during RESP aborts the transaction and clears the pointer
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        a4[2] = 4'd4; b4[2] = 4'd9;
        bus.req_valid = 4'b0100;
        wait_grant(4, 4'b0100, "grant_pre_rst");
        q4.push_back(mk(2, LT));
        @(posedge clk); #1;
        a4[0] = 4'hA; b4[0] = 4'hA;
        a4[3] = 4'h1; b4[3] = 4'hE;
        bus.req_valid = 4'b1001;
        wait_rsp("rsp_pre_rst");
        #1;
        rst = 1'b1;
        q4.delete();
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_req_ready", int'(bus.req_ready), 0);
        check("midrst_rsp_id", 32'(bus.rsp_id), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_grant(4, 4'b0001, "grant_after_rst");
        q4.push_back(mk(0, EQ));
        @(posedge clk); #1;
        bus.req_valid = 4'b1000;
        wait_grant(4, 4'b1000, "grant_after_rst_next");
        q4.push_back(mk(3, LT));
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain("drain_rst");

        // NUM_REQ=3: pointer wraps from 2 to 0
        @(posedge clk); #1;
        bus3.rsp_ready = 1'b1;
        a3[2] = 4'd3; b3[2] = 4'd3;
        bus3.req_valid = 3'b100;
        wait_grant(3, 4'b0100, "grant3_req2");
        q3.push_back(mk(2, EQ));
        @(posedge clk); #1;
        a3[0] = 4'd1; b3[0] = 4'd2;
        a3[1] = 4'd7; b3[1] = 4'd0;
        bus3.req_valid = 3'b011;
        wait_grant(3, 4'b0001, "grant3_wrap");
        q3.push_back(mk(0, LT));
        wait_grant(3, 4'b0010, "grant3_next");
        q3.push_back(mk(1, GT));
        @(posedge clk); #1;
        bus3.req_valid = '0;
        wait_drain("drain3");

        check("q4_empty", q4.size(), 0);
        check("q3_empty", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
